conv_ctrl: RTL

CONV_CTRL -- requirements
Module: conv_ctrl

---
 rtl/conv_ctrl.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/conv_ctrl.sv
// 3x3 convolution controller: loads a kernel and an image over a valid/ready
// stream, then walks every fully-covered 3x3 window of the image buffer and
// streams out one signed 20-bit result per window.
module conv_ctrl #(
  parameter int unsigned IMG_W = 8,
  parameter int unsigned IMG_H = 8,
  parameter int unsigned AW    = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_data,
  output logic          buf_we,
  output logic [AW-1:0] buf_waddr,
  output logic [7:0]    buf_wdata,
  output logic [AW-1:0] buf_raddr,
  input  logic [7:0]    buf_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [19:0]   out_data,
  output logic          busy,
  output logic          done
);

  localparam int unsigned NPix = IMG_W * IMG_H;
  localparam logic [AW-1:0] LastPix = AW'(NPix - 1);
  localparam logic [AW-1:0] LastCol = AW'(IMG_W - 3);
  localparam logic [AW-1:0] LastRow = AW'(IMG_H - 3);

  typedef enum logic [2:0] {
    StIdle,
    StLoadK,
    StLoadI,
    StConv,
    StOut,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          kcnt_q, kcnt_d;   // kernel word index during LOAD_K
  logic [AW-1:0]       pix_q, pix_d;     // pixel index during LOAD_I
  logic [AW-1:0]       row_q, row_d;     // window top-left row
  logic [AW-1:0]       col_q, col_d;     // window top-left column
  logic [3:0]          tap_q, tap_d;     // CONV cycle within a window, 0..9
  logic signed [19:0]  acc_q, acc_d;
  logic signed [7:0]   k_q [9];
  logic                k_we;

  logic signed [7:0]   tap_k;
  logic signed [15:0]  prod;
  int unsigned         dr, dc;

  // Tap weight and product for the read issued one cycle earlier (tap_q - 1).
  always_comb begin
    tap_k = '0;
    if (tap_q != 4'd0 && tap_q < 4'd10) begin
      tap_k = k_q[tap_q - 4'd1];
    end
    prod = $signed(buf_rdata) * tap_k;
    dr   = 32'(tap_q) / 3;
    dc   = 32'(tap_q) % 3;
  end

  // Next-state, counters and all outputs; every output defaults to its idle value.
  always_comb begin
    state_d   = state_q;
    kcnt_d    = kcnt_q;
    pix_d     = pix_q;
    row_d     = row_q;
    col_d     = col_q;
    tap_d     = tap_q;
    acc_d     = acc_q;
    k_we      = 1'b0;
    in_ready  = 1'b0;
    buf_we    = 1'b0;
    buf_waddr = '0;
    buf_wdata = '0;
    buf_raddr = '0;
    out_valid = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoadK;
          kcnt_d  = '0;
          pix_d   = '0;
          row_d   = '0;
          col_d   = '0;
          tap_d   = '0;
          acc_d   = '0;
        end
      end

      StLoadK: begin
        in_ready = 1'b1;
        if (in_valid) begin
          k_we = 1'b1;
          if (kcnt_q == 4'd8) begin
            kcnt_d  = '0;
            state_d = StLoadI;
          end else begin
            kcnt_d = kcnt_q + 4'd1;
          end
        end
      end

      StLoadI: begin
        in_ready = 1'b1;
        if (in_valid) begin
          buf_we    = 1'b1;
          buf_waddr = pix_q;
          buf_wdata = in_data;
          if (pix_q == LastPix) begin
            pix_d   = '0;
            tap_d   = '0;
            state_d = StConv;
          end else begin
            pix_d = pix_q + AW'(1);
          end
        end
      end

      StConv: begin
        // Cycle t issues the read for tap t; cycle t+1 accumulates it.
        if (tap_q < 4'd9) begin
          buf_raddr = AW'((32'(row_q) + dr) * IMG_W + 32'(col_q) + dc);
        end
        if (tap_q == 4'd0) begin
          acc_d = '0;
        end else begin
          acc_d = acc_q + {{4{prod[15]}}, prod};
        end
        if (tap_q == 4'd9) begin
          tap_d   = '0;
          state_d = StOut;
        end else begin
          tap_d = tap_q + 4'd1;
        end
      end

      StOut: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (col_q == LastCol) begin
            col_d = '0;
            if (row_q == LastRow) begin
              row_d   = '0;
              state_d = StDone;
            end else begin
              row_d   = row_q + AW'(1);
              state_d = StConv;
            end
          end else begin
            col_d   = col_q + AW'(1);
            state_d = StConv;
          end
        end
      end

      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  assign busy     = (state_q != StIdle);
  assign out_data = acc_q;

  // State, counters and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      kcnt_q  <= '0;
      pix_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      tap_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      kcnt_q  <= kcnt_d;
      pix_q   <= pix_d;
      row_q   <= row_d;
      col_q   <= col_d;
      tap_q   <= tap_d;
      acc_q   <= acc_d;
    end
  end

  // Kernel tap registers; they keep their values between jobs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) begin
        k_q[i] <= '0;
      end
    end else if (k_we) begin
      k_q[kcnt_q] <= in_data;
    end
  end

endmodule
